// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the ID/EX hazard control slice
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MUL_BUSY = 1'b1
   } state_e;

   localparam int REG_AW_DEF = 5;

   typedef struct packed {
      logic load;
      logic wr;
   } ex_ctl_t;

   // Control fields of the NOP that a bubble places in ID/EX
   localparam ex_ctl_t EX_CTL_NOP = '{load: 1'b0, wr: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID/EX stall, bubble and flush control with multiply sequencing
module hazard_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_is_mul,
   input  logic              ex_branch_taken,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              if_id_flush,
   output logic              id_ex_en,
   output logic              id_ex_bubble,
   output logic              busy_mul,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int MCW = $clog2(MUL_LAT);
   localparam logic [MCW-1:0] MCNT_INIT = MCW'(MUL_LAT - 2);

   state_e            state_q, state_d;
   logic [MCW-1:0]    mcnt_q, mcnt_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   ex_ctl_t           ex_ctl_q, ex_ctl_d;
   logic              load_use;
   logic              stall_inc;
   logic              flush_inc;

   assign load_use = id_valid & ex_ctl_q.load & ex_ctl_q.wr & (ex_rd_q != '0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd_q)) |
                      (id_use_rs2 & (id_rs2 == ex_rd_q)));

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b0;
      busy_mul     = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      state_d      = state_q;
      mcnt_d       = mcnt_q;
      if (rst) begin
         pc_en        = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (state_q == MUL_BUSY) begin
         // ID/EX holds the multiply; a taken branch cannot be resolved here
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         busy_mul  = 1'b1;
         stall_inc = 1'b1;
         if (mcnt_q == '0) begin
            state_d = RUN;
         end else begin
            mcnt_d = mcnt_q - MCW'(1);
         end
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         flush_inc    = 1'b1;
      end else if (load_use) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
         stall_inc    = 1'b1;
      end else if (id_valid && id_is_mul) begin
         state_d = MUL_BUSY;
         mcnt_d  = MCNT_INIT;
      end
   end

   // Shadow tracks exactly what the ID/EX register will hold after this edge
   always_comb begin
      ex_rd_d  = ex_rd_q;
      ex_ctl_d = ex_ctl_q;
      if (id_ex_en && id_ex_bubble) begin
         ex_rd_d  = '0;
         ex_ctl_d = EX_CTL_NOP;
      end else if (id_ex_en) begin
         ex_rd_d  = id_rd;
         ex_ctl_d = '{load: id_mem_read & id_valid, wr: id_reg_write & id_valid};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         mcnt_q   <= '0;
         ex_rd_q  <= '0;
         ex_ctl_q <= EX_CTL_NOP;
      end else begin
         state_q  <= state_d;
         mcnt_q   <= mcnt_d;
         ex_rd_q  <= ex_rd_d;
         ex_ctl_q <= ex_ctl_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_inc),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_use_rs1, id_use_rs2;
   logic       id_reg_write, id_mem_read, id_is_mul;
   logic       ex_branch_taken;

   logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, busy_mul;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_bubble, s_busy_mul;
   logic [3:0]  s_stall_cnt, s_flush_cnt;
   logic [5:0]  ctl;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, busy_mul}
   assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, busy_mul};

   localparam logic [5:0] C_RESET = 6'b011110;
   localparam logic [5:0] C_RUN   = 6'b110100;
   localparam logic [5:0] C_STALL = 6'b000110;
   localparam logic [5:0] C_FLUSH = 6'b111110;
   localparam logic [5:0] C_MUL   = 6'b000001;

   hazard_stall_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_mul(id_is_mul),
      .ex_branch_taken(ex_branch_taken), .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
      .busy_mul(busy_mul), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_stall_ctrl #(.CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_mul(id_is_mul),
      .ex_branch_taken(ex_branch_taken), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
      .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en), .id_ex_bubble(s_id_ex_bubble),
      .busy_mul(s_busy_mul), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mul);
      id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_is_mul = mul;
   endtask

   task automatic set_idle();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL reset_pre_mul ctl=%b exp=%b", ctl, C_RUN); end
      cyc();
      set_idle();
      #1;
      checks++;
      if (ctl !== C_MUL) begin errors++; $display("FAIL reset_in_mul ctl=%b exp=%b", ctl, C_MUL); end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (ctl !== C_RESET) begin errors++; $display("FAIL reset_forced[%0d] ctl=%b exp=%b", i, ctl, C_RESET); end
         cyc();
      end
      rst = 1'b0;
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL reset_after ctl=%b exp=%b", ctl, C_RUN); end
      checks++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_counters stall=%0d flush=%0d exp=0/0", stall_cnt, flush_cnt);
      end
      cyc();
   endtask

   task automatic test_load_use();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL lu_load ctl=%b exp=%b", ctl, C_RUN); end
      cyc();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (ctl !== C_STALL) begin errors++; $display("FAIL lu_stall ctl=%b exp=%b", ctl, C_STALL); end
      cyc();
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL lu_resume ctl=%b exp=%b", ctl, C_RUN); end
      checks++;
      if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
      cyc();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      cyc();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL lu_x0 ctl=%b exp=%b", ctl, C_RUN); end
      cyc();
      checks++;
      if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_x0_cnt got=%0d exp=1", stall_cnt); end
   endtask

   task automatic test_no_false_hazard();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      cyc();
      set_id(1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL nofalse ctl=%b exp=%b", ctl, C_RUN); end
      cyc();
      checks++;
      if (stall_cnt !== 16'd1) begin errors++; $display("FAIL nofalse_cnt got=%0d exp=1", stall_cnt); end
      set_idle();
      cyc();
   endtask

   task automatic test_multiply();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL mul_issue ctl=%b exp=%b", ctl, C_RUN); end
      cyc();
      set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         ex_branch_taken = (i == 1);
         #1;
         checks++;
         if (ctl !== C_MUL) begin errors++; $display("FAIL mul_hold[%0d] ctl=%b exp=%b", i, ctl, C_MUL); end
         cyc();
         ex_branch_taken = 1'b0;
      end
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL mul_done ctl=%b exp=%b", ctl, C_RUN); end
      checks++;
      if (stall_cnt !== 16'd4 || flush_cnt !== 16'd0) begin
         errors++; $display("FAIL mul_counters stall=%0d flush=%0d exp=4/0", stall_cnt, flush_cnt);
      end
      cyc();
   endtask

   task automatic test_branch_vs_load_use();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      cyc();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      ex_branch_taken = 1'b1;
      #1;
      checks++;
      if (ctl !== C_FLUSH) begin errors++; $display("FAIL br_vs_lu ctl=%b exp=%b", ctl, C_FLUSH); end
      cyc();
      ex_branch_taken = 1'b0;
      #1;
      checks++;
      if (ctl !== C_RUN) begin errors++; $display("FAIL br_after ctl=%b exp=%b", ctl, C_RUN); end
      checks++;
      if (flush_cnt !== 16'd1 || stall_cnt !== 16'd4) begin
         errors++; $display("FAIL br_counters flush=%0d stall=%0d exp=1/4", flush_cnt, stall_cnt);
      end
      set_idle();
      cyc();
   endtask

   task automatic test_saturation();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         #1;
         checks++;
         if (s_pc_en !== ((i % 2) == 0)) begin
            errors++; $display("FAIL sat_pc_en[%0d] got=%b exp=%b", i, s_pc_en, ((i % 2) == 0));
         end
         cyc();
      end
      checks++;
      if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall4 got=%0d exp=15", s_stall_cnt); end
      checks++;
      if (stall_cnt !== 16'd24) begin errors++; $display("FAIL sat_stall16 got=%0d exp=24", stall_cnt); end
      checks++;
      if (s_flush_cnt !== 4'd1) begin errors++; $display("FAIL sat_flush4 got=%0d exp=1", s_flush_cnt); end
      set_idle();
      cyc();
   endtask

   initial begin
      rst = 1'b1;
      ex_branch_taken = 1'b0;
      set_idle();
      cyc();
      cyc();
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_multiply();
      test_branch_vs_load_use();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control block at the ID/EX boundary, on the producing side of the ID/EX pipeline register.
- Decides each cycle whether the decoded instruction advances into ID/EX, is held, or is replaced by a bubble. Drives the enable and flush controls for the PC, IF/ID and ID/EX registers.
- Keeps a registered shadow of the EX-stage control fields to detect load-use hazards.
- Sequences multi-cycle multiply stalls and branch-taken flushes, and keeps saturating stall and flush counters.

Parameters:
- REG_AW, 5, register-address width.
- MUL_LAT, 4, EX occupancy of a multiply in cycles; must be >= 2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  REG_AW  source register 1.
- id_rs2  in  REG_AW  source register 2.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- id_is_mul  in  1  instruction is a multi-cycle multiply.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clears to NOP.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_bubble  out  1  ID/EX loads a NOP instead of the ID bundle.
- busy_mul  out  1  FSM is in MUL_BUSY.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flush events.

Behaviour:
- FSM states are RUN and MUL_BUSY, plus a down-counter mcnt of width clog2(MUL_LAT).
- Shadow registers ex_rd, ex_load, ex_wr mirror what ID/EX holds. They capture id_rd, id_mem_read & id_valid, and id_reg_write & id_valid on every cycle where id_ex_en=1 and id_ex_bubble=0. They clear to 0 when id_ex_en=1 and id_ex_bubble=1.
- Define load_use = id_valid & ex_load & ex_wr & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Outputs are combinational from state, shadow registers and inputs. Priority in RUN, highest first:
  1. ex_branch_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_bubble=1. flush_cnt increments. Any load_use in the same cycle is ignored.
  2. load_use: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1. stall_cnt increments. Exactly one bubble is inserted, because the shadow clears and the hazard resolves on the next cycle through forwarding.
  3. Otherwise: all enables 1, flush and bubble 0.
- Multiply issue: a multiply enters ID/EX when id_valid & id_is_mul and case 3 applies. On that edge the FSM goes to MUL_BUSY and mcnt loads MUL_LAT-2.
- In MUL_BUSY:
  - pc_en, if_id_en and id_ex_en are 0, and if_id_flush and id_ex_bubble are 0, so ID/EX holds the multiply.
  - stall_cnt increments each cycle.
  - ex_branch_taken is ignored.
  - If mcnt==0, the next state is RUN; otherwise mcnt decrements.
  - Total hold is exactly MUL_LAT-1 cycles.
- Counters saturate at all-ones and never wrap.
- rst:
  - State returns to RUN and mcnt, shadow registers, stall_cnt and flush_cnt clear to 0.
  - While rst is high, outputs are forced to pc_en=0, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_bubble=1, busy_mul=0, which flushes the pipe.
  - Asserting rst mid-MUL_BUSY aborts the multiply; the first cycle after reset is RUN.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state enum (RUN=0, MUL_BUSY=1), the REG_AW default and the NOP encoding used by bubbles.
- One sub-module, sat_counter (CNT_W, inc, rst), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
1. Reset: assert rst for 2 cycles while in MUL_BUSY -> forced flush outputs, then RUN with all enables 1, busy_mul=0, counters 0.
2. Load-use: issue lw x5, then id rs1=5 with use_rs1=1 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1, then normal advance; stall_cnt=1. Repeat with rd=x0 -> no stall.
3. No false hazard: load to x5 followed by an instruction reading only x6 (use_rs2=0 with rs2=5) -> no stall.
4. Multiply with MUL_LAT=4: issue mul -> busy_mul=1 and id_ex_en=0 for exactly 3 cycles, then RUN; stall_cnt=3. ex_branch_taken pulsed mid-stall -> ignored, flush_cnt=0.
5. Branch vs load-use in the same cycle -> flush wins: if_id_flush=1, id_ex_bubble=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
6. Saturation with CNT_W=4: 20 consecutive load-use stalls -> stall_cnt holds 15.
